// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator scheduler.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package elevator_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_MOVING       = 3'd1,
        S_DOOR_OPENING = 3'd2,
        S_DOOR_OPEN    = 3'd3,
        S_DOOR_CLOSING = 3'd4
    } sched_state_t;

    // door_status encodings
    localparam logic [1:0] DOOR_CLOSED  = 2'b00;
    localparam logic [1:0] DOOR_OPENING = 2'b01;
    localparam logic [1:0] DOOR_OPEN    = 2'b10;
    localparam logic [1:0] DOOR_CLOSING = 2'b11;

    // floor numbers
    localparam logic [1:0] ST_FLOOR = 2'd0;
    localparam logic [1:0] ND_FLOOR = 2'd1;
    localparam logic [1:0] RD_FLOOR = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when some pending call lies strictly beyond flr in the given direction.
    function automatic logic req_ahead(input logic [2:0] req, input logic [1:0] flr,
                                       input logic up);
        logic r;
        r = 1'b0;
        case (flr)
            ST_FLOOR: r = up ? |req[2:1] : 1'b0;
            ND_FLOOR: r = up ? req[2]    : req[0];
            RD_FLOOR: r = up ? 1'b0      : |req[1:0];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter shared by all timed scheduler states; done while the count is zero.
// Latency: load takes effect on the next edge; count holds at zero once reached.
// Backpressure: none (load always accepted).
// Ports: clk, rst (async active-high), load/value (reload), done (count == 0).
module sched_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: latches per-floor calls, sequences travel and the door cycle.
// Latency: call visible on req_led one edge after sampling; IDLE acts on the following edge.
// Backpressure: none; calls are level-sampled every cycle and latched until serviced.
// Ports: clk, rst (async active-high), call_req[2:0], obstruct (only with DOOR_REOPEN_EN),
//        floor[1:0], is_moving, dir_up, door_status[1:0], req_led[2:0].
// Build option: define DOOR_REOPEN_EN to add the obstruct input and door reopening.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 4,
    parameter int OPEN_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef DOOR_REOPEN_EN
    input  logic       obstruct,
`endif
    input  logic [2:0] call_req,
    output logic [1:0] floor,
    output logic       is_moving,
    output logic       dir_up,
    output logic [1:0] door_status,
    output logic [2:0] req_led
);

    localparam int TW = $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, OPEN_CYCLES)) + 1;

    // Timers count N-1 down to 0 so each timed state lasts exactly N cycles.
    localparam logic [TW-1:0] TRV_LD  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);

    sched_state_t  r_state;
    logic [1:0]    r_floor;
    logic          r_dir;
    logic [2:0]    r_req;

    sched_state_t  w_state_nxt;
    logic [1:0]    w_floor_nxt;
    logic [1:0]    w_step_floor;
    logic          w_dir_nxt;
    logic          w_load;
    logic [TW-1:0] w_ld_val;
    logic          w_done;
    logic [2:0]    w_flr_oh;
    logic          w_here;
    logic          w_obs;
    logic          w_reopen;
    logic [2:0]    w_set;
    logic [2:0]    w_clr;

    assign w_flr_oh = 3'b001 << r_floor;
    assign w_here   = |(call_req & w_flr_oh);

`ifdef DOOR_REOPEN_EN
    assign w_obs    = obstruct;
    assign w_reopen = obstruct | w_here;
`else
    assign w_obs    = 1'b0;
    assign w_reopen = 1'b0;
`endif

    sched_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .value (w_ld_val),
        .done  (w_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir;
        w_load       = 1'b0;
        w_ld_val     = '0;
        w_step_floor = r_dir ? (r_floor + 2'd1) : (r_floor - 2'd1);
        case (r_state)
            S_IDLE: begin
                if (|(r_req & w_flr_oh)) begin
                    w_state_nxt = S_DOOR_OPENING;
                    w_load      = 1'b1;
                    w_ld_val    = DOOR_LD;
                end else if (req_ahead(r_req, r_floor, r_dir)) begin
                    w_state_nxt = S_MOVING;
                    w_load      = 1'b1;
                    w_ld_val    = TRV_LD;
                end else if (req_ahead(r_req, r_floor, ~r_dir)) begin
                    w_dir_nxt   = ~r_dir;
                    w_state_nxt = S_MOVING;
                    w_load      = 1'b1;
                    w_ld_val    = TRV_LD;
                end
            end
            S_MOVING: begin
                if (w_done) begin
                    w_floor_nxt = w_step_floor;
                    // End floors pin the scan direction so the next sweep turns around.
                    if (w_step_floor == ST_FLOOR) begin
                        w_dir_nxt = 1'b1;
                    end else if (w_step_floor == RD_FLOOR) begin
                        w_dir_nxt = 1'b0;
                    end
                    if (|(r_req & (3'b001 << w_step_floor))) begin
                        w_state_nxt = S_DOOR_OPENING;
                        w_load      = 1'b1;
                        w_ld_val    = DOOR_LD;
                    end else if (req_ahead(r_req, w_step_floor, r_dir)) begin
                        w_load   = 1'b1;
                        w_ld_val = TRV_LD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DOOR_OPENING: begin
                if (w_done) begin
                    w_state_nxt = S_DOOR_OPEN;
                    w_load      = 1'b1;
                    w_ld_val    = OPEN_LD;
                end
            end
            S_DOOR_OPEN: begin
                // A same-floor call (or obstruction) restarts the full hold time.
                if (w_here || w_obs) begin
                    w_load   = 1'b1;
                    w_ld_val = OPEN_LD;
                end else if (w_done) begin
                    w_state_nxt = S_DOOR_CLOSING;
                    w_load      = 1'b1;
                    w_ld_val    = DOOR_LD;
                end
            end
            S_DOOR_CLOSING: begin
                if (w_reopen) begin
                    w_state_nxt = S_DOOR_OPENING;
                    w_load      = 1'b1;
                    w_ld_val    = DOOR_LD;
                end else if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Same-floor calls are dropped while the door is opening/open; entering
    // DOOR_OPENING clears that floor's latch and wins over a simultaneous set.
    assign w_set = call_req & ~(((r_state == S_DOOR_OPENING) || (r_state == S_DOOR_OPEN))
                                ? w_flr_oh : 3'b000);
    assign w_clr = ((w_state_nxt == S_DOOR_OPENING) && (r_state != S_DOOR_OPENING))
                   ? (3'b001 << w_floor_nxt) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_floor <= ST_FLOOR;
            r_dir   <= 1'b1;
            r_req   <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_floor <= w_floor_nxt;
            r_dir   <= w_dir_nxt;
            r_req   <= (r_req | w_set) & ~w_clr;
        end
    end

    always_comb begin
        door_status = DOOR_CLOSED;
        case (r_state)
            S_DOOR_OPENING: door_status = DOOR_OPENING;
            S_DOOR_OPEN:    door_status = DOOR_OPEN;
            S_DOOR_CLOSING: door_status = DOOR_CLOSING;
            default:        door_status = DOOR_CLOSED;
        endcase
    end

    assign floor     = r_floor;
    assign is_moving = (r_state == S_MOVING);
    assign dir_up    = r_dir;
    assign req_led   = r_req;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with default timing (travel 16, door 4, open 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_scheduler;

    logic       clk;
    logic       rst;
    logic       obstruct;
    logic [2:0] call_req;
    logic [1:0] floor;
    logic       is_moving;
    logic       dir_up;
    logic [1:0] door_status;
    logic [2:0] req_led;

    int n_checks;
    int n_errors;

    elevator_scheduler dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DOOR_REOPEN_EN
        .obstruct    (obstruct),
`endif
        .call_req    (call_req),
        .floor       (floor),
        .is_moving   (is_moving),
        .dir_up      (dir_up),
        .door_status (door_status),
        .req_led     (req_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] call;
        int         n;
        logic [1:0] f;
        logic       mv;
        logic [1:0] dr;
        logic [2:0] rq;
        logic       dir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] c, input int n, input logic [1:0] f, input logic mv,
                       input logic [1:0] dr, input logic [2:0] rq, input logic dir);
        vec_t v;
        v.call = c; v.n = n; v.f = f; v.mv = mv; v.dr = dr; v.rq = rq; v.dir = dir;
        tbl.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [1:0] f, input logic mv,
                         input logic [1:0] dr, input logic [2:0] rq, input logic dir);
        n_checks++;
        if ({floor, is_moving, door_status, req_led, dir_up} !== {f, mv, dr, rq, dir}) begin
            n_errors++;
            $display("FAIL %s: got floor=%b mov=%b door=%b req=%b dir=%b, want floor=%b mov=%b door=%b req=%b dir=%b",
                     name, floor, is_moving, door_status, req_led, dir_up, f, mv, dr, rq, dir);
        end
    endtask

    // Runs one full door cycle at the current floor starting from a call in IDLE,
    // ending in DOOR_CLOSING (closing counter at DOOR_CYCLES-1).
    task automatic call_to_closing(input logic [2:0] c, input logic [1:0] f, input logic dir);
        call_req = c;
        tick(1);
        call_req = 3'b000;
        tick(1);
        check("seq_open_entry", f, 1'b0, 2'b01, 3'b000, dir);
        tick(4);
        tick(8);
        check("seq_closing_entry", f, 1'b0, 2'b11, 3'b000, dir);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        obstruct = 1'b0;
        call_req = 3'b000;
        rst      = 1'b1;

        //   call    n   floor mv door   req     dir
        add(3'b000,  0, 2'd0, 0, 2'b00, 3'b000, 1);  // reset state
        add(3'b100,  1, 2'd0, 0, 2'b00, 3'b100, 1);  // call latched
        add(3'b000,  1, 2'd0, 1, 2'b00, 3'b100, 1);  // IDLE -> MOVING
        add(3'b000, 15, 2'd0, 1, 2'b00, 3'b100, 1);
        add(3'b000,  1, 2'd1, 1, 2'b00, 3'b100, 1);  // pass floor 1
        add(3'b000, 15, 2'd1, 1, 2'b00, 3'b100, 1);
        add(3'b000,  1, 2'd2, 0, 2'b01, 3'b000, 0);  // 32 moving cycles, arrive
        add(3'b000,  3, 2'd2, 0, 2'b01, 3'b000, 0);
        add(3'b000,  1, 2'd2, 0, 2'b10, 3'b000, 0);
        add(3'b000,  7, 2'd2, 0, 2'b10, 3'b000, 0);
        add(3'b000,  1, 2'd2, 0, 2'b11, 3'b000, 0);
        add(3'b000,  3, 2'd2, 0, 2'b11, 3'b000, 0);
        add(3'b000,  1, 2'd2, 0, 2'b00, 3'b000, 0);  // back to IDLE
        add(3'b101,  1, 2'd2, 0, 2'b00, 3'b101, 0);  // calls at 0 and 2
        add(3'b000,  1, 2'd2, 0, 2'b01, 3'b001, 0);  // current floor first
        add(3'b000,  4, 2'd2, 0, 2'b10, 3'b001, 0);
        add(3'b000,  8, 2'd2, 0, 2'b11, 3'b001, 0);
        add(3'b000,  4, 2'd2, 0, 2'b00, 3'b001, 0);
        add(3'b000,  1, 2'd2, 1, 2'b00, 3'b001, 0);  // head down
        add(3'b000, 16, 2'd1, 1, 2'b00, 3'b001, 0);  // floor 1 not requested
        add(3'b000, 16, 2'd0, 0, 2'b01, 3'b000, 1);  // floor 0 forces up
        add(3'b000,  4, 2'd0, 0, 2'b10, 3'b000, 1);
        add(3'b000,  8, 2'd0, 0, 2'b11, 3'b000, 1);
        add(3'b000,  4, 2'd0, 0, 2'b00, 3'b000, 1);
        add(3'b110,  1, 2'd0, 0, 2'b00, 3'b110, 1);  // calls at 1 and 2
        add(3'b000,  1, 2'd0, 1, 2'b00, 3'b110, 1);
        add(3'b000, 16, 2'd1, 0, 2'b01, 3'b100, 1);  // stop at 1
        add(3'b000,  4, 2'd1, 0, 2'b10, 3'b100, 1);
        add(3'b000,  8, 2'd1, 0, 2'b11, 3'b100, 1);
        add(3'b000,  4, 2'd1, 0, 2'b00, 3'b100, 1);
        add(3'b000,  1, 2'd1, 1, 2'b00, 3'b100, 1);  // continue up
        add(3'b000, 16, 2'd2, 0, 2'b01, 3'b000, 0);
        add(3'b000,  4, 2'd2, 0, 2'b10, 3'b000, 0);
        add(3'b000,  8, 2'd2, 0, 2'b11, 3'b000, 0);
        add(3'b000,  4, 2'd2, 0, 2'b00, 3'b000, 0);

        tick(2);
        rst = 1'b0;

        foreach (tbl[i]) begin
            call_req = tbl[i].call;
            if (tbl[i].n > 0) begin
                tick(1);
                call_req = 3'b000;
                tick(tbl[i].n - 1);
            end
            check($sformatf("row%0d", i), tbl[i].f, tbl[i].mv, tbl[i].dr, tbl[i].rq, tbl[i].dir);
        end

        // Same-floor call while open at floor 1 restarts the 8-cycle hold.
        call_req = 3'b010;
        tick(1);
        call_req = 3'b000;
        check("ext_latch", 2'd2, 1'b0, 2'b00, 3'b010, 1'b0);
        tick(1);
        tick(16);
        check("ext_arrive", 2'd1, 1'b0, 2'b01, 3'b000, 1'b0);
        tick(4);
        tick(3);
        call_req = 3'b010;
        tick(1);
        call_req = 3'b000;
        check("ext_no_latch", 2'd1, 1'b0, 2'b10, 3'b000, 1'b0);
        tick(7);
        check("ext_still_open", 2'd1, 1'b0, 2'b10, 3'b000, 1'b0);
        tick(1);
        check("ext_closing", 2'd1, 1'b0, 2'b11, 3'b000, 1'b0);
        tick(4);
        check("ext_idle", 2'd1, 1'b0, 2'b00, 3'b000, 1'b0);

        // Obstruction in cycle 2 of closing.
        call_to_closing(3'b010, 2'd1, 1'b0);
        tick(1);
        obstruct = 1'b1;
        tick(1);
        obstruct = 1'b0;
`ifdef DOOR_REOPEN_EN
        check("obs_reopen", 2'd1, 1'b0, 2'b01, 3'b000, 1'b0);
        tick(4);
        check("obs_open", 2'd1, 1'b0, 2'b10, 3'b000, 1'b0);
        tick(8);
        check("obs_close", 2'd1, 1'b0, 2'b11, 3'b000, 1'b0);
        tick(4);
        check("obs_idle", 2'd1, 1'b0, 2'b00, 3'b000, 1'b0);
`else
        check("obs_ignored", 2'd1, 1'b0, 2'b11, 3'b000, 1'b0);
        tick(2);
        check("obs_idle", 2'd1, 1'b0, 2'b00, 3'b000, 1'b0);
`endif

        // Same-floor call during closing.
        call_to_closing(3'b010, 2'd1, 1'b0);
        tick(1);
        call_req = 3'b010;
        tick(1);
        call_req = 3'b000;
`ifdef DOOR_REOPEN_EN
        check("cc_reopen", 2'd1, 1'b0, 2'b01, 3'b000, 1'b0);
        tick(4);
        check("cc_open", 2'd1, 1'b0, 2'b10, 3'b000, 1'b0);
        tick(12);
        check("cc_idle", 2'd1, 1'b0, 2'b00, 3'b000, 1'b0);
`else
        check("cc_latched", 2'd1, 1'b0, 2'b11, 3'b010, 1'b0);
        tick(2);
        check("cc_idle", 2'd1, 1'b0, 2'b00, 3'b010, 1'b0);
        tick(1);
        check("cc_reopen", 2'd1, 1'b0, 2'b01, 3'b000, 1'b0);
`endif

        // Reset mid-trip from floor 0 toward floor 2.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_home", 2'd0, 1'b0, 2'b00, 3'b000, 1'b1);
        call_req = 3'b100;
        tick(1);
        call_req = 3'b000;
        tick(1);
        tick(20);
        check("rst_midtrip", 2'd1, 1'b1, 2'b00, 3'b100, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 2'd0, 1'b0, 2'b00, 3'b000, 1'b1);
        tick(1);
        check("rst_held", 2'd0, 1'b0, 2'b00, 3'b000, 1'b1);
        rst = 1'b0;
        tick(3);
        check("rst_calls_lost", 2'd0, 1'b0, 2'b00, 3'b000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Central controller for the three-floor elevator. It latches hall/cabin calls per floor and picks the next stop with a direction-preserving (SCAN) policy. It sequences travel and the door cycle with internal timers, and drives the current floor, motion flag, door status and per-floor call LEDs. It sits above the movement and door-status logic and is the only block that decides when the car moves and when the door opens.

## Interface
- `TRAVEL_CYCLES`, default 16: clock cycles to travel one floor; legal range is ≥1.
- `DOOR_CYCLES`, default 4: clock cycles spent in the opening phase, and also in the closing phase; legal range is ≥1.
- `OPEN_CYCLES`, default 8: clock cycles the door is held fully open; legal range is ≥1.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `call_req` input 3: call button per floor; bit0 = floor 0, bit2 = floor 2. A level sampled each cycle; a 1-cycle pulse is sufficient.
- `obstruct` input 1: door obstruction sensor. This port exists only with `DOOR_REOPEN_EN`.
- `floor` output 2: current floor. Values are 2'b00, 2'b01, 2'b10; 2'b11 is never driven.
- `is_moving` output 1: high while travelling between floors.
- `dir_up` output 1: current scan direction; 1 = up.
- `door_status` output 2: 00 = closed, 01 = opening, 10 = open, 11 = closing.
- `req_led` output 3: pending-call indicator per floor.

## Operation
- States: IDLE, MOVING, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
  - `door_status` in each state: IDLE and MOVING drive 00; DOOR_OPENING drives 01; DOOR_OPEN drives 10; DOOR_CLOSING drives 11.
- `is_moving` is high only in MOVING.
- Call latch: `req_led[i]` is set by `call_req[i]` and cleared when the car begins servicing floor i. Servicing begins on entry to DOOR_OPENING at floor i.
  - If a call arrives for the current floor while the state is DOOR_OPENING or DOOR_OPEN, it is not latched.
  - In DOOR_OPEN, such a call reloads the open timer to `OPEN_CYCLES`.
  - If a set and a clear for the same floor occur in the same cycle, the clear wins.
- Scheduling in IDLE, evaluated every cycle:
  1. A request at the current floor goes to DOOR_OPENING.
  2. Otherwise, a request strictly ahead in `dir_up` goes to MOVING.
  3. Otherwise, a request behind flips `dir_up` and goes to MOVING.
  4. Otherwise, stay in IDLE.
- Direction is forced: at floor 0, `dir_up` = 1; at floor 2, `dir_up` = 0.
- MOVING: the timer loads `TRAVEL_CYCLES`. On expiry, `floor` steps by ±1, then:
  - If `req_led` of the new floor is set, go to DOOR_OPENING.
  - Else, if a request remains ahead, reload the timer and stay in MOVING.
  - Else, go to IDLE.
- Door sequence: DOOR_OPENING (`DOOR_CYCLES`) → DOOR_OPEN (`OPEN_CYCLES`) → DOOR_CLOSING (`DOOR_CYCLES`) → IDLE.
  - `floor` never changes outside MOVING.
- A call latched during DOOR_CLOSING for the current floor remains pending. IDLE then reopens the door on the next cycle.

## Timing
- Reset values: IDLE, `floor` = 00, `dir_up` = 1, `is_moving` = 0, `door_status` = 00, `req_led` = 000, all timers 0.
- `req_led` rises one cycle after `call_req` is sampled (registered).
- IDLE decisions are registered: the state changes on the edge after a request becomes visible in `req_led`.
- Each timed state lasts exactly N cycles, where N is its parameter. The timer counts N−1 down to 0 and exits on 0.
- Call to door opening, same floor, from IDLE: `call_req` high at edge k gives `req_led` at k+1 and DOOR_OPENING at k+2.
- One-floor trip with an idle car: MOVING spans exactly `TRAVEL_CYCLES` cycles, and `floor` updates on the same edge that leaves MOVING.
- Timer width is $clog2 of the maximum of the three parameters, plus 1.
- Reset asserted mid-operation (moving or door open) returns everything to the reset values immediately. Latched calls are lost.

## Configuration
- `DOOR_REOPEN_EN` defined:
  - The `obstruct` port exists.
  - During DOOR_CLOSING, `obstruct` = 1 or a same-floor call transitions to DOOR_OPENING with a fresh `DOOR_CYCLES`.
  - During DOOR_OPEN, `obstruct` = 1 holds the open timer at `OPEN_CYCLES`.
- `DOOR_REOPEN_EN` undefined:
  - No `obstruct` port.
  - Closing always completes.
  - A same-floor call during closing is latched and serviced from IDLE.

## Structure
- Shared package `elevator_pkg`:
  - State enum `sched_state_t`.
  - Door codes `DOOR_CLOSED`, `DOOR_OPENING`, `DOOR_OPEN`, `DOOR_CLOSING` (2-bit).
  - Floor constants `ST_FLOOR`, `ND_FLOOR`, `RD_FLOOR`.
- One sub-module, `sched_timer`: a loadable down-counter with a `load`/`value` input and a `done` output. It is shared by all timed states.

## Test plan
- Reset in the middle of MOVING from floor 0 toward floor 2 → next cycle: `floor` = 00, `is_moving` = 0, `req_led` = 000, `door_status` = 00.
- Idle at floor 0, pulse `call_req` = 100, defaults → `req_led` = 100. `is_moving` stays high 32 cycles, then `floor` = 10. The door goes 01/10/11 for 4/8/4 cycles, and `req_led` clears on entry to opening.
- Car moving up from floor 0 with `req_led` = 110 → stops at floor 1 and runs the door cycle, then continues to floor 2. `dir_up` stays 1 until floor 2, then becomes 0.
- At floor 1 in DOOR_OPEN, pulse `call_req` = 010 → `req_led` stays 000 and the open phase extends to 8 cycles after the pulse.
- At floor 2 with `dir_up` = 0, pulse `call_req` = 001 and `call_req` = 100 together → floor 2 is serviced first with no motion, then the car moves to floor 0.
- With `DOOR_REOPEN_EN`, assert `obstruct` in cycle 2 of DOOR_CLOSING → `door_status` returns to 01 for 4 cycles, then a full open/close cycle follows. Without the macro, the same stimulus finishes closing.
